// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Brief    : Moore-style main controller for the multicycle MIPS datapath.
//            Sequences each instruction through FETCH / DECODE / EXECUTE /
//            MEMORY / WRITEBACK and drives the PC, IR, memory, ALU-mux and
//            register-file enables.
// Options  : MC_WAIT_STATES_EN - when defined, FETCH, MEM_READ and MEM_WRITE
//            stall until mem_ready=1. When undefined, mem_ready is ignored.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       BranchNE,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal,
  output logic [3:0] state
);

  // --------------------------------------------------------------------------
  // State encoding (visible on the debug state port)
  // --------------------------------------------------------------------------
  localparam logic [3:0] c_START     = 4'd0;
  localparam logic [3:0] c_FETCH     = 4'd1;
  localparam logic [3:0] c_DECODE    = 4'd2;
  localparam logic [3:0] c_MEM_ADDR  = 4'd3;
  localparam logic [3:0] c_MEM_READ  = 4'd4;
  localparam logic [3:0] c_MEM_WB    = 4'd5;
  localparam logic [3:0] c_MEM_WRITE = 4'd6;
  localparam logic [3:0] c_R_EXEC    = 4'd7;
  localparam logic [3:0] c_R_WB      = 4'd8;
  localparam logic [3:0] c_BRANCH    = 4'd9;
  localparam logic [3:0] c_JUMP      = 4'd10;
  localparam logic [3:0] c_I_EXEC    = 4'd11;
  localparam logic [3:0] c_I_WB      = 4'd12;
  localparam logic [3:0] c_JAL       = 4'd13;

  // --------------------------------------------------------------------------
  // Opcodes (IR[31:26])
  // --------------------------------------------------------------------------
  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_JAL   = 6'b000011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_SLTI  = 6'b001010;
  localparam logic [5:0] c_OP_SLTIU = 6'b001011;
  localparam logic [5:0] c_OP_ANDI  = 6'b001100;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_XORI  = 6'b001110;
  localparam logic [5:0] c_OP_LUI   = 6'b001111;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;

  // ALUOp codes
  localparam logic [1:0] c_ALU_ADD   = 2'b00;
  localparam logic [1:0] c_ALU_SUB   = 2'b01;
  localparam logic [1:0] c_ALU_FUNCT = 2'b10;
  localparam logic [1:0] c_ALU_SLT   = 2'b11;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic       w_mem_done;
  logic       w_is_itype;
  logic       w_op_known;

  // --------------------------------------------------------------------------
  // Memory handshake: with wait states the memory states stall on mem_ready,
  // otherwise every access completes in its single cycle.
  // --------------------------------------------------------------------------
`ifdef MC_WAIT_STATES_EN
  assign w_mem_done = mem_ready;
`else
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = mem_ready;
  assign w_mem_done         = 1'b1;
`endif

  // Immediate-format ALU instructions all share the I_EXEC/I_WB path.
  assign w_is_itype = (opcode == c_OP_ADDI) || (opcode == c_OP_ANDI) ||
                      (opcode == c_OP_ORI)  || (opcode == c_OP_XORI) ||
                      (opcode == c_OP_SLTI) || (opcode == c_OP_SLTIU) ||
                      (opcode == c_OP_LUI);

  // Every opcode the controller can dispatch; anything else is flagged.
  assign w_op_known = w_is_itype ||
                      (opcode == c_OP_LW)  || (opcode == c_OP_SW)  ||
                      (opcode == c_OP_RTYPE) ||
                      (opcode == c_OP_BEQ) || (opcode == c_OP_BNE) ||
                      (opcode == c_OP_J)   || (opcode == c_OP_JAL);

  assign state = r_state;

  // State register; reset asynchronously parks the controller in START.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_START;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: fixed sequencing per instruction class.
  always_comb begin
    w_next_state = c_FETCH;
    case (r_state)
      c_START: begin
        w_next_state = c_FETCH;
      end
      c_FETCH: begin
        w_next_state = w_mem_done ? c_DECODE : c_FETCH;
      end
      c_DECODE: begin
        if ((opcode == c_OP_LW) || (opcode == c_OP_SW)) begin
          w_next_state = c_MEM_ADDR;
        end else if (opcode == c_OP_RTYPE) begin
          w_next_state = c_R_EXEC;
        end else if ((opcode == c_OP_BEQ) || (opcode == c_OP_BNE)) begin
          w_next_state = c_BRANCH;
        end else if (opcode == c_OP_J) begin
          w_next_state = c_JUMP;
        end else if (opcode == c_OP_JAL) begin
          w_next_state = c_JAL;
        end else if (w_is_itype) begin
          w_next_state = c_I_EXEC;
        end else begin
          // Unknown opcode: drop it and fetch the next instruction.
          w_next_state = c_FETCH;
        end
      end
      c_MEM_ADDR: begin
        w_next_state = (opcode == c_OP_SW) ? c_MEM_WRITE : c_MEM_READ;
      end
      c_MEM_READ: begin
        w_next_state = w_mem_done ? c_MEM_WB : c_MEM_READ;
      end
      c_MEM_WB: begin
        w_next_state = c_FETCH;
      end
      c_MEM_WRITE: begin
        w_next_state = w_mem_done ? c_FETCH : c_MEM_WRITE;
      end
      c_R_EXEC: begin
        w_next_state = c_R_WB;
      end
      c_R_WB: begin
        w_next_state = c_FETCH;
      end
      c_BRANCH: begin
        w_next_state = c_FETCH;
      end
      c_JUMP: begin
        w_next_state = c_FETCH;
      end
      c_I_EXEC: begin
        w_next_state = c_I_WB;
      end
      c_I_WB: begin
        w_next_state = c_FETCH;
      end
      c_JAL: begin
        w_next_state = c_FETCH;
      end
      default: begin
        // Encodings 14 and 15 are unreachable; recover into FETCH.
        w_next_state = c_FETCH;
      end
    endcase
  end

  // Output decode: Moore outputs from state, with opcode refining BRANCH,
  // DECODE (illegal flag) and I_EXEC (ALU operation).
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    BranchNE    = 1'b0;
    RegDst      = 2'b00;
    MemToReg    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = c_ALU_ADD;
    PCSource    = 2'b00;
    illegal     = 1'b0;
    case (r_state)
      c_FETCH: begin
        // PC+4 and IR capture only commit on the cycle the read completes.
        MemRead  = 1'b1;
        IRWrite  = w_mem_done;
        PCWrite  = w_mem_done;
        IorD     = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b01;
        ALUOp    = c_ALU_ADD;
        PCSource = 2'b00;
      end
      c_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        ALUSrcA = 1'b0;
        ALUSrcB = 2'b11;
        ALUOp   = c_ALU_ADD;
        illegal = ~w_op_known;
      end
      c_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = c_ALU_ADD;
      end
      c_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      c_MEM_WB: begin
        RegWrite = 1'b1;
        RegDst   = 2'b00;
        MemToReg = 2'b01;
      end
      c_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      c_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b00;
        ALUOp   = c_ALU_FUNCT;
      end
      c_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 2'b01;
        MemToReg = 2'b00;
      end
      c_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b00;
        ALUOp       = c_ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        BranchNE    = (opcode == c_OP_BNE);
      end
      c_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      c_JAL: begin
        // PC still holds PC+4 this cycle, so the link value is captured
        // before the jump target lands in PC.
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        RegWrite = 1'b1;
        RegDst   = 2'b10;
        MemToReg = 2'b10;
      end
      c_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if ((opcode == c_OP_ANDI) || (opcode == c_OP_ORI) ||
            (opcode == c_OP_XORI)) begin
          ALUOp = c_ALU_FUNCT;
        end else if ((opcode == c_OP_SLTI) || (opcode == c_OP_SLTIU)) begin
          ALUOp = c_ALU_SLT;
        end else begin
          ALUOp = c_ALU_ADD;
        end
      end
      c_I_WB: begin
        RegWrite = 1'b1;
        RegDst   = 2'b00;
        MemToReg = 2'b00;
      end
      default: begin
        // START and unreachable encodings drive everything inactive.
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Self-checking bench for multicycle_control. An instruction-level
//            model expands each opcode into its expected per-cycle state and
//            control word; a compare process checks the DUT every cycle.
//            Honours MC_WAIT_STATES_EN the same way the design does.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multicycle_control;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       ALUSrcA, RegWrite, BranchNE, illegal;
  logic [1:0] RegDst, MemToReg, ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, mrd, mwr, irw, srca, rw, bne;
    logic [1:0] rdst, m2r, srcb, aluop, pcsrc;
    logic       ill;
  } exp_t;

  exp_t act;
  exp_t q[$];
  exp_t bld_e[$];
  logic bld_r[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  multicycle_control dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .BranchNE(BranchNE),
    .RegDst(RegDst), .MemToReg(MemToReg), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal(illegal), .state(state)
  );

  always #5 clock = ~clock;

  always_comb act = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                     IRWrite, ALUSrcA, RegWrite, BranchNE, RegDst, MemToReg,
                     ALUSrcB, ALUOp, PCSource, illegal};

  // Per-cycle checker: every queued expectation is matched on a falling edge.
  always @(negedge clock) begin
    cyc++;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL cycle cyc=%0d got=%h want=%h (state got %0d want %0d)",
                 cyc, act, e, act.st, e.st);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic exp_t blank(input logic [3:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  task automatic add(input exp_t e, input logic rdy);
    bld_e.push_back(e);
    bld_r.push_back(rdy);
  endtask

  // A memory access: w stalled cycles then the completing one when wait
  // states exist; otherwise one cycle that ignores mem_ready.
  task automatic mem_phase(input exp_t e_wait, input exp_t e_done, input int w);
`ifdef MC_WAIT_STATES_EN
    for (int i = 0; i < w; i++) add(e_wait, 1'b0);
    add(e_done, 1'b1);
`else
    add(e_done, (w > 0) ? 1'b0 : 1'b1);
`endif
  endtask

  function automatic bit is_imm(input logic [5:0] op);
    return op inside {6'b001000, 6'b001100, 6'b001101, 6'b001110,
                      6'b001010, 6'b001011, 6'b001111};
  endfunction

  // Expand one instruction into its expected cycle list.
  task automatic build(input logic [5:0] op, input int fw, input int mw);
    exp_t f, fwt, d, e, w;
    bit   known;
    bld_e.delete();
    bld_r.delete();
    f = blank(4'd1);
    f.mrd = 1'b1;
    f.srcb = 2'b01;
    fwt = f;
    f.irw = 1'b1;
    f.pcw = 1'b1;
    mem_phase(fwt, f, fw);
    known = is_imm(op) || (op inside {6'b100011, 6'b101011, 6'b000000,
                                      6'b000100, 6'b000101, 6'b000010,
                                      6'b000011});
    d = blank(4'd2);
    d.srcb = 2'b11;
    d.ill = !known;
    add(d, 1'b1);
    if (op == 6'b100011 || op == 6'b101011) begin
      e = blank(4'd3);
      e.srca = 1'b1;
      e.srcb = 2'b10;
      add(e, 1'b1);
      if (op == 6'b100011) begin
        e = blank(4'd4);
        e.mrd = 1'b1;
        e.iord = 1'b1;
        mem_phase(e, e, mw);
        w = blank(4'd5);
        w.rw = 1'b1;
        w.m2r = 2'b01;
        add(w, 1'b1);
      end else begin
        e = blank(4'd6);
        e.mwr = 1'b1;
        e.iord = 1'b1;
        mem_phase(e, e, mw);
      end
    end else if (op == 6'b000000) begin
      e = blank(4'd7);
      e.srca = 1'b1;
      e.aluop = 2'b10;
      add(e, 1'b1);
      w = blank(4'd8);
      w.rw = 1'b1;
      w.rdst = 2'b01;
      add(w, 1'b1);
    end else if (op == 6'b000100 || op == 6'b000101) begin
      e = blank(4'd9);
      e.srca = 1'b1;
      e.aluop = 2'b01;
      e.pcwc = 1'b1;
      e.pcsrc = 2'b01;
      e.bne = (op == 6'b000101);
      add(e, 1'b1);
    end else if (op == 6'b000010) begin
      e = blank(4'd10);
      e.pcw = 1'b1;
      e.pcsrc = 2'b10;
      add(e, 1'b1);
    end else if (op == 6'b000011) begin
      e = blank(4'd13);
      e.pcw = 1'b1;
      e.pcsrc = 2'b10;
      e.rw = 1'b1;
      e.rdst = 2'b10;
      e.m2r = 2'b10;
      add(e, 1'b1);
    end else if (is_imm(op)) begin
      e = blank(4'd11);
      e.srca = 1'b1;
      e.srcb = 2'b10;
      if (op inside {6'b001100, 6'b001101, 6'b001110}) e.aluop = 2'b10;
      else if (op inside {6'b001010, 6'b001011}) e.aluop = 2'b11;
      else e.aluop = 2'b00;
      add(e, 1'b1);
      w = blank(4'd12);
      w.rw = 1'b1;
      add(w, 1'b1);
    end
  endtask

  // Called #1 after the edge that entered FETCH; returns #1 after the edge
  // that enters the next FETCH.
  task automatic run(input logic [5:0] op, input int fw, input int mw);
    build(op, fw, mw);
    q = bld_e;
    opcode = op;
    for (int i = 0; i < bld_r.size(); i++) begin
      mem_ready = bld_r[i];
      @(posedge clock);
      #1;
    end
    mem_ready = 1'b1;
    chk($sformatf("drain op=%b", op), q.size(), 0);
    chk($sformatf("back_to_fetch op=%b", op), {28'd0, state}, 32'd1);
  endtask

  task automatic release_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    q.push_back(blank(4'd0));
    @(posedge clock);
    #1;
    chk("first_fetch", {state, MemRead, IRWrite, PCWrite, ALUSrcB},
        {4'd1, 1'b1, 1'b1, 1'b1, 2'b01});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_sw_wait;
    // Model pins: hand-counted cycles per instruction.
    build(6'b100011, 0, 0); chk("len_lw", bld_e.size(), 5);
    build(6'b101011, 0, 0); chk("len_sw", bld_e.size(), 4);
    build(6'b000000, 0, 0); chk("len_r", bld_e.size(), 4);
    build(6'b001000, 0, 0); chk("len_addi", bld_e.size(), 4);
    build(6'b000100, 0, 0); chk("len_beq", bld_e.size(), 3);
    build(6'b000011, 0, 0); chk("len_jal", bld_e.size(), 3);
    build(6'b111111, 0, 0); chk("len_illegal", bld_e.size(), 2);
    build(6'b000101, 0, 0); chk("bne_word", bld_e[2], 32'h0094280A);
`ifdef MC_WAIT_STATES_EN
    exp_sw_wait = 7;
`else
    exp_sw_wait = 4;
`endif
    build(6'b101011, 0, 3); chk("len_sw_wait", bld_e.size(), exp_sw_wait);

    // Asynchronous reset with no clock edge involved.
    #2;
    reset_n = 1'b0;
    #1;
    chk("reset_async", act, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("reset_hold", act, 32'd0);
    release_reset();

    run(6'b100011, 0, 0);   // lw
    run(6'b101011, 0, 0);   // sw
    run(6'b000000, 0, 0);   // R-type
    run(6'b000100, 0, 0);   // beq
    run(6'b000101, 0, 0);   // bne
    run(6'b000010, 0, 0);   // j
    run(6'b000011, 0, 0);   // jal
    run(6'b001000, 0, 0);   // addi
    run(6'b001100, 0, 0);   // andi
    run(6'b001101, 0, 0);   // ori
    run(6'b001110, 0, 0);   // xori
    run(6'b001010, 0, 0);   // slti
    run(6'b001011, 0, 0);   // sltiu
    run(6'b001111, 0, 0);   // lui
    run(6'b111111, 0, 0);   // unknown
    run(6'b010001, 0, 0);   // unknown
    run(6'b101011, 0, 3);   // sw, memory stalls
    run(6'b100011, 2, 1);   // lw, fetch and read stalls
    run(6'b000000, 1, 0);   // R-type, fetch stall

    // Reset in the middle of R_EXEC must abort with all outputs inactive.
    build(6'b000000, 0, 0);
    for (int i = 0; i < 3; i++) q.push_back(bld_e[i]);
    opcode = 6'b000000;
    repeat (2) @(posedge clock);
    #1;
    chk("mid_r_exec", {28'd0, state}, 32'd7);
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_reset_outs", act, 32'd0);
    chk("mid_reset_queue", q.size(), 0);
    release_reset();
    run(6'b100011, 0, 0);

    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
